// File: rtl/relay_symbol_rx_if.sv
// Relay receiver link bundle: encoded line and enable in, recovered symbol strobes out.
interface relay_symbol_rx_if;
    logic       enable;
    logic       rx_in;
    logic [3:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output enable, rx_in,
        input  data_out, data_valid, frame_err, busy
    );

    modport slave (
        input  enable, rx_in,
        output data_out, data_valid, frame_err, busy
    );
endinterface

// File: rtl/relay_symbol_rx.sv
// Oversampling receiver for framed 4-bit relay symbols (start 1, 4 data MSB first, stop 0).
// Define RELAY_RX_PARITY_EN to expect an even-parity bit between data bit 3 and the stop bit.
module relay_symbol_rx #(
    parameter int unsigned BIT_CLKS = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    relay_symbol_rx_if.slave rx
);
    localparam int unsigned MID_CNT  = BIT_CLKS / 2 - 1;
    localparam int unsigned LAST_CNT = BIT_CLKS - 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
`ifdef RELAY_RX_PARITY_EN
        PARITY   = 3'd3,
`endif
        STOP     = 3'd4,
        ERR_WAIT = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             sync1;
    logic             rxs;
    logic             rxs_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       bit_idx;
    logic [1:0]       bit_idx_nxt;
    logic [3:0]       shadow;
    logic [3:0]       shadow_nxt;
    logic [3:0]       data_out_q;
    logic [3:0]       data_out_nxt;
    logic             data_valid_q;
    logic             data_valid_nxt;
    logic             frame_err_q;
    logic             frame_err_nxt;
    logic             busy_q;
    logic             busy_nxt;
    logic             rise_c;
    logic             mid_c;
    logic             stop_bad_c;
`ifdef RELAY_RX_PARITY_EN
    logic             par_err;
    logic             par_err_nxt;
`endif

    assign rise_c = rxs & ~rxs_d;
    assign mid_c  = (cnt == CNT_W'(MID_CNT));
`ifdef RELAY_RX_PARITY_EN
    assign stop_bad_c = rxs | par_err;
`else
    assign stop_bad_c = rxs;
`endif

    assign rx.data_out   = data_out_q;
    assign rx.data_valid = data_valid_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.busy       = busy_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; enable low aborts any frame in progress
    always_comb begin
        state_nxt = state;
        if (!rx.enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (rise_c) state_nxt = START;
                START:    if (mid_c)  state_nxt = rxs ? DATA : IDLE;
`ifdef RELAY_RX_PARITY_EN
                DATA:     if (mid_c && bit_idx == 2'd3) state_nxt = PARITY;
                PARITY:   if (mid_c)  state_nxt = STOP;
`else
                DATA:     if (mid_c && bit_idx == 2'd3) state_nxt = STOP;
`endif
                STOP:     if (mid_c)  state_nxt = rxs ? ERR_WAIT : IDLE;
                ERR_WAIT: if (!rxs)   state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // Datapath and registered-output next values; counter is reloaded while idle so
    // every mid-bit point is referenced to the start edge and no drift builds up
    always_comb begin
        cnt_nxt        = '0;
        bit_idx_nxt    = bit_idx;
        shadow_nxt     = shadow;
        data_out_nxt   = data_out_q;
        data_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        busy_nxt       = (state_nxt != IDLE);
`ifdef RELAY_RX_PARITY_EN
        par_err_nxt    = par_err;
`endif
        if (rx.enable) begin
            if (state != IDLE && state != ERR_WAIT)
                cnt_nxt = (cnt == CNT_W'(LAST_CNT)) ? '0 : cnt + CNT_W'(1);
            case (state)
                START: begin
                    bit_idx_nxt = 2'd0;
`ifdef RELAY_RX_PARITY_EN
                    par_err_nxt = 1'b0;
`endif
                end
                DATA: if (mid_c) begin
                    shadow_nxt  = {shadow[2:0], rxs};
                    bit_idx_nxt = bit_idx + 2'd1;
                end
`ifdef RELAY_RX_PARITY_EN
                PARITY: if (mid_c) par_err_nxt = ^{shadow, rxs};
`endif
                STOP: if (mid_c) begin
                    if (stop_bad_c) begin
                        frame_err_nxt = 1'b1;
                    end else begin
                        data_valid_nxt = 1'b1;
                        data_out_nxt   = shadow;
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchroniser, datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1        <= 1'b0;
            rxs          <= 1'b0;
            rxs_d        <= 1'b0;
            cnt          <= '0;
            bit_idx      <= 2'd0;
            shadow       <= 4'h0;
            data_out_q   <= 4'h0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef RELAY_RX_PARITY_EN
            par_err      <= 1'b0;
`endif
        end else begin
            sync1        <= rx.rx_in;
            rxs          <= sync1;
            rxs_d        <= rxs;
            cnt          <= cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            shadow       <= shadow_nxt;
            data_out_q   <= data_out_nxt;
            data_valid_q <= data_valid_nxt;
            frame_err_q  <= frame_err_nxt;
            busy_q       <= busy_nxt;
`ifdef RELAY_RX_PARITY_EN
            par_err      <= par_err_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_relay_symbol_rx.sv
// Bench for relay_symbol_rx: directed and random frames against a frame-level timing model.
module tb_relay_symbol_rx;
    localparam int BIT = 16;
`ifdef RELAY_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int LAT    = 107;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int LAT    = 91;
`endif

    logic clk = 1'b0;
    logic reset;
    relay_symbol_rx_if rx ();

    relay_symbol_rx #(.BIT_CLKS(BIT), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic       en_v  = 1'b1;
    logic [3:0] exp_dout = 4'h0;

    logic       line_q[$];
    int         ev_cyc[$];
    logic       ev_ok[$];
    logic [3:0] ev_data[$];
    int         bz_cyc[$];
    logic       bz_val[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_bits(input logic v, input int n);
        for (int i = 0; i < n; i++) line_q.push_back(v);
    endtask

    // Queue one frame on the line and record its outcome from the frame rules
    task automatic send_frame(input logic [3:0] d, input logic stop_b, input logic par_flip,
                              output int c);
        logic ok;
        c = cyc + line_q.size();
        push_bits(1'b1, BIT);
        for (int i = 3; i >= 0; i--) push_bits(d[i], BIT);
        if (PAR_EN) push_bits((^d) ^ par_flip, BIT);
        push_bits(stop_b, BIT);
        ok = !stop_b && !(PAR_EN && par_flip);
        ev_cyc.push_back(c + LAT);
        ev_ok.push_back(ok);
        ev_data.push_back(d);
    endtask

    task automatic bsy(input int at, input logic v);
        bz_cyc.push_back(at);
        bz_val.push_back(v);
    endtask

    task automatic check_cycle();
        logic exp_v;
        logic exp_e;
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (ev_cyc.size() != 0 && ev_cyc[0] == cyc) begin
            if (ev_ok[0]) begin
                exp_v    = 1'b1;
                exp_dout = ev_data[0];
            end else begin
                exp_e = 1'b1;
            end
            void'(ev_cyc.pop_front());
            void'(ev_ok.pop_front());
            void'(ev_data.pop_front());
        end
        chk("data_valid", 32'(rx.data_valid), 32'(exp_v));
        chk("frame_err", 32'(rx.frame_err), 32'(exp_e));
        chk("data_out", 32'(rx.data_out), 32'(exp_dout));
        while (bz_cyc.size() != 0 && bz_cyc[0] == cyc) begin
            chk("busy", 32'(rx.busy), 32'(bz_val[0]));
            void'(bz_cyc.pop_front());
            void'(bz_val.pop_front());
        end
    endtask

    // Called at the falling edge of cycle cyc: check outputs, drive this cycle's inputs
    task automatic step();
        check_cycle();
        rx.rx_in  = (line_q.size() != 0) ? line_q.pop_front() : 1'b0;
        rx.enable = en_v;
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until(input int k);
        while (cyc < k) step();
    endtask

    task automatic drain();
        run_until(cyc + line_q.size() + 40);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int c2;
        reset     = 1'b0;
        rx.enable = 1'b1;
        rx.rx_in  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data_out", 32'(rx.data_out), 32'h0);
        chk("rst_data_valid", 32'(rx.data_valid), 32'h0);
        chk("rst_frame_err", 32'(rx.frame_err), 32'h0);
        chk("rst_busy", 32'(rx.busy), 32'h0);
        reset = 1'b1;
        run_until(10);

        // Single good frame 4'hA
        send_frame(4'hA, 1'b0, 1'b0, c);
        bsy(c + 3, 1'b1);
        bsy(c + 50, 1'b1);
        bsy(c + LAT + 1, 1'b0);
        drain();

        // Start glitch shorter than half a bit
        c = cyc;
        push_bits(1'b1, 5);
        bsy(c + 5, 1'b1);
        bsy(c + 11, 1'b0);
        drain();

        // Bad stop bit, line stuck high afterwards
        send_frame(4'h5, 1'b1, 1'b0, c);
        push_bits(1'b1, 40);
        push_bits(1'b0, 10);
        bsy(c + LAT + 29, 1'b1);
        bsy(c + BIT * (6 + int'(PAR_EN)) + 44, 1'b0);
        drain();

        // Back-to-back frames with no idle gap
        send_frame(4'h3, 1'b0, 1'b0, c);
        send_frame(4'hC, 1'b0, 1'b0, c2);
        bsy(c + LAT + 1 + BIT / 2, 1'b1);
        drain();

        // Enable dropped after data bit 1
        send_frame(4'hF, 1'b0, 1'b0, c);
        void'(ev_cyc.pop_back());
        void'(ev_ok.pop_back());
        void'(ev_data.pop_back());
        bsy(c + 44, 1'b1);
        bsy(c + 46, 1'b0);
        run_until(c + 45);
        en_v = 1'b0;
        run_until(c + 130);
        en_v = 1'b1;
        run_until(c + 140);

`ifdef RELAY_RX_PARITY_EN
        // 4'h6 is even already, so a parity bit of 1 is an error
        send_frame(4'h6, 1'b0, 1'b1, c);
        drain();
`endif

        // Random frames with random stop/parity faults and gaps
        for (int n = 0; n < 24; n++) begin
            logic [3:0] d;
            logic       sb;
            logic       pf;
            d  = 4'($urandom);
            sb = ($urandom_range(3) == 0);
            pf = PAR_EN && ($urandom_range(3) == 0);
            send_frame(d, sb, pf, c);
            if (sb) begin
                push_bits(1'b1, int'($urandom_range(30, 2)));
                push_bits(1'b0, int'($urandom_range(10, 2)));
            end else begin
                push_bits(1'b0, int'($urandom_range(20, 0)));
            end
        end
        drain();

        chk("events_left", 32'(ev_cyc.size()), 32'd0);
        chk("busy_checks_left", 32'(bz_cyc.size()), 32'd0);
        chk("idle_busy", 32'(rx.busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/relay_symbol_rx.md
Name: relay_symbol_rx

Overview:
- Serial receiver for the relay link; the far-end counterpart of the relay symbol encoder.
- Oversamples the encoded relay line on the system clock and recovers framed 4-bit symbols.
- Presents each recovered symbol with a one-cycle valid strobe, in the same data/available form the relay mode logic consumes.
- Sits between the relay input pin and the relay mode/decode path.

Parameters:
- BIT_CLKS, 16: clk cycles per serial bit. Must be even and >= 4.
- CNT_W, 5: bit-counter width. Must satisfy 2^CNT_W > BIT_CLKS.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- enable  in  1  receiver enable. Low forces IDLE.
- rx_in  in  1  encoded relay line; asynchronous to clk.
- data_out  out  4  last good symbol. Bit 3 is the first received data bit.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- frame_err  out  1  one-cycle pulse on a bad stop (or parity) bit.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Frame format:
  - idle level 0;
  - start bit 1;
  - 4 data bits, MSB first;
  - [parity bit, see Optional Feature];
  - stop bit 0.
- Synchroniser: 2-flop chain on rx_in. "rxs" below is the second stage.
  - Let T0 be the first cycle where rxs=1 and its previous value was 0.
- Reset (reset=0 at a clock edge):
  - state=IDLE, bit counter 0, sync flops 0;
  - data_out=4'h0, data_valid=0, frame_err=0, busy=0.
- States: IDLE, START, DATA, PARITY (only with the option), STOP, ERR_WAIT.
- IDLE:
  - On a 0->1 edge of rxs with enable=1: go to START, clear the counter.
  - Otherwise stay in IDLE.
- START:
  - Sample rxs at T0+BIT_CLKS/2.
  - If 1: go to DATA with the bit index set to 0.
  - If 0 (glitch): return to IDLE silently, no pulses.
- DATA:
  - Data bit i (i=0..3) is sampled at T0+BIT_CLKS/2+(i+1)*BIT_CLKS and shifted into a shadow register.
  - After bit 3, go to STOP (or to PARITY when the option is enabled).
- STOP:
  - Sample at the next mid-bit point.
  - If 0: on the following cycle, data_out takes the shadow value and data_valid=1 for exactly 1 cycle; go to IDLE.
  - If 1: on the following cycle frame_err=1 for 1 cycle, data_out is unchanged; go to ERR_WAIT.
- ERR_WAIT: stay until rxs=0, then go to IDLE. A line stuck high never produces a second frame.
- Counter:
  - Counts 0..BIT_CLKS-1 and wraps.
  - The mid-bit point is count == BIT_CLKS/2-1 after the START reload.
  - No drift accumulates across the frame.
- Latency with the default parameter:
  - rx_in edge captured at cycle c gives T0=c+2.
  - data_valid fires at T0+5*BIT_CLKS+BIT_CLKS/2+1 = c+91.
- Pulse exclusivity: data_valid and frame_err are never high in the same cycle.
- enable deasserted mid-frame: next cycle state=IDLE; partial symbol discarded, no pulses, data_out held.
- Reset mid-frame has the same effect as enable deasserted, plus all outputs go to their reset values.
- Back-to-back frames:
  - A new start edge is accepted from the first IDLE cycle after STOP.
  - This includes a start edge arriving during the remaining half stop bit.
- A rising edge seen while busy is ignored.

Optional Feature:
- Macro: RELAY_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows data bit 3 and is sampled in PARITY at the next mid-bit point.
  - Parity is checked over the 4 data bits plus the parity bit.
  - On mismatch, STOP still runs, but the frame ends as an error: frame_err pulse, data_out held, ERR_WAIT only if the stop bit is also 1.
  - data_valid is delayed by BIT_CLKS (c+107 with the default parameter).
- Undefined: PARITY state and its logic are absent; the frame is 6 bits.

Test Plan:
- Reset with reset=0 for 3 cycles, then 1 -> all outputs 0, busy=0, data_out=4'h0.
- Frame with data 4'hA, BIT_CLKS=16, rx_in edge at cycle c -> data_valid single pulse at c+91, data_out=4'hA, frame_err=0, busy low at c+92.
- rx_in high for 5 cycles then low (glitch) -> no data_valid, no frame_err, busy drops after the START sample.
- Frame 4'h5 with stop bit 1, line held high 40 more cycles -> frame_err pulse, data_out keeps its previous value, no new frame until the line returns to 0.
- Two back-to-back frames 4'h3 then 4'hC, second start edge 8 cycles after the first stop sample -> two data_valid pulses 96 cycles apart, values 3 then C.
- enable dropped after data bit 1 of frame 4'hF -> no pulses, data_out unchanged. With RELAY_RX_PARITY_EN, 4'h6 sent with parity 1 -> frame_err pulse, no data_valid.
